// File: rtl/upower_x_pkg.sv
// Shared definitions for the uPOWER X-format issue path: field positions,
// opcode constants, sequencer states and the legality check used on both sides.
package upower_x_pkg;

    localparam logic [5:0] PO_X    = 6'd31;

    localparam logic [8:0] XO_AND  = 9'd28;
    localparam logic [8:0] XO_ANDC = 9'd60;
    localparam logic [8:0] XO_NOR  = 9'd124;
    localparam logic [8:0] XO_XOR  = 9'd316;
    localparam logic [8:0] XO_OR   = 9'd444;
    localparam logic [8:0] XO_NAND = 9'd476;
    localparam logic [8:0] XO_ADD  = 9'd266;
    localparam logic [8:0] XO_SUBF = 9'd40;

    localparam int PO_HI  = 31;
    localparam int PO_LO  = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RA_HI  = 20;
    localparam int RA_LO  = 16;
    localparam int RB_HI  = 15;
    localparam int RB_LO  = 11;
    localparam int OE_BIT = 10;
    localparam int XO_HI  = 9;
    localparam int XO_LO  = 1;
    localparam int RC_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_ISSUE,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic [5:0] po;
        logic [4:0] rs;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [8:0] xo;
        logic       rc;
    } xfields_t;

    function automatic xfields_t split_x(input logic [31:0] w);
        xfields_t f;
        f.po = w[PO_HI:PO_LO];
        f.rs = w[RS_HI:RS_LO];
        f.ra = w[RA_HI:RA_LO];
        f.rb = w[RB_HI:RB_LO];
        f.xo = w[XO_HI:XO_LO];
        f.rc = w[RC_BIT];
        return f;
    endfunction

    function automatic logic legal_x(input logic [31:0] w);
        logic xo_ok;
        case (w[XO_HI:XO_LO])
            XO_AND, XO_ANDC, XO_NOR, XO_XOR,
            XO_OR, XO_NAND, XO_ADD, XO_SUBF: xo_ok = 1'b1;
            default:                         xo_ok = 1'b0;
        endcase
        return xo_ok && (w[PO_HI:PO_LO] == PO_X) && !w[OE_BIT];
    endfunction

endpackage

// File: rtl/upower_imem.sv
// Instruction store: one synchronous write port for program load and one
// synchronous read port with single-cycle latency; contents are not reset.
module upower_imem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/upower_x_issue.sv
// Fetch/decode/issue sequencer: walks the instruction store from address 0 and
// hands legal X-format instructions one at a time to the executor.
//
// state  | meaning
// IDLE   | waiting for start; done/illegal from the last run stay visible
// FETCH  | memory read at pc in flight
// DECODE | read word split into fields and checked for legality
// ISSUE  | issue_valid high, fields/pc frozen until the executor takes them
// FINISH | empty run: flag done and return to IDLE
module upower_x_issue
    import upower_x_pkg::*;
#(
    parameter  int IMEM_DEPTH = 64,
    localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    input  logic              start,
    input  logic [ADDR_W:0]   n_instr,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [5:0]        PO,
    output logic [4:0]        rs,
    output logic [4:0]        ra,
    output logic [4:0]        rb,
    output logic [8:0]        XO,
    output logic              Rc,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic              illegal
);

    localparam logic [ADDR_W:0] DEPTH_CNT = IMEM_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   count_q, count_d;
    xfields_t          fld_q, fld_d;
    logic              done_q, done_d;
    logic              illegal_q, illegal_d;

    logic [31:0]       rdata;
    logic              prog_wr;
    logic              fetch_rd;
    logic              last_instr;

    assign prog_wr    = prog_we && (state_q == ST_IDLE);
    assign fetch_rd   = (state_q == ST_FETCH);
    assign last_instr = ({1'b0, pc_q} == (count_q - CNT_ONE));

    upower_imem #(
        .DEPTH (IMEM_DEPTH),
        .AW    (ADDR_W)
    ) u_imem (
        .clk   (clk),
        .we    (prog_wr),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (fetch_rd),
        .raddr (pc_q),
        .rdata (rdata)
    );

    // Terminal transitions out of DECODE/ISSUE apply FINISH's effect on the
    // same edge, so done rises and busy falls in the cycle right after.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        count_d   = count_q;
        fld_d     = fld_q;
        done_d    = done_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    illegal_d = 1'b0;
                    pc_d      = '0;
                    count_d   = (n_instr > DEPTH_CNT) ? DEPTH_CNT : n_instr;
                    state_d   = (n_instr == '0) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                fld_d = split_x(rdata);
                if (legal_x(rdata)) begin
                    state_d = ST_ISSUE;
                end else begin
                    illegal_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    if (last_instr) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            count_q   <= '0;
            fld_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            fld_q     <= fld_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign issue_valid = (state_q == ST_ISSUE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign pc          = pc_q;
    assign PO          = fld_q.po;
    assign rs          = fld_q.rs;
    assign ra          = fld_q.ra;
    assign rb          = fld_q.rb;
    assign XO          = fld_q.xo;
    assign Rc          = fld_q.rc;

endmodule

// File: tb/tb_upower_x_issue.sv
// Directed bench for the X-format issue sequencer.
module tb_upower_x_issue;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic        start;
    logic [6:0]  n_instr;
    logic        issue_valid;
    logic        issue_ready;
    logic [5:0]  PO;
    logic [4:0]  rs;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [8:0]  XO;
    logic        Rc;
    logic [5:0]  pc;
    logic        busy;
    logic        done;
    logic        illegal;

    upower_x_issue #(.IMEM_DEPTH(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .n_instr     (n_instr),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .PO          (PO),
        .rs          (rs),
        .ra          (ra),
        .rb          (rb),
        .XO          (XO),
        .Rc          (Rc),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          hs_cnt, valid_cnt, stall_cnt, unstable, first_valid, end_cyc;
    bit          timed_out;
    logic [1:0]  flags_at_1;
    logic [30:0] hs_fld [64];
    logic [5:0]  hs_pc  [64];
    logic [3:0]  rpat = 4'b1001;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkx(input logic [4:0] s, input logic [4:0] a,
                                        input logic [4:0] b, input logic [8:0] x,
                                        input logic c);
        return {6'd31, s, a, b, 1'b0, x, c};
    endfunction

    function automatic logic [30:0] fx(input logic [4:0] s, input logic [4:0] a,
                                       input logic [4:0] b, input logic [8:0] x,
                                       input logic c);
        return {6'd31, s, a, b, x, c};
    endfunction

    task automatic prog_load(input logic [5:0] addr, input logic [31:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        step();
        prog_we   = 1'b0;
    endtask

    // mode 0: ready always high; mode 1: ready follows a 1-0-0-1 pattern
    task automatic run_seq(input logic [6:0] n, input int mode, input int budget);
        int          cyc;
        bit          prev_stall;
        logic [36:0] cur, prev;
        hs_cnt = 0; valid_cnt = 0; stall_cnt = 0; unstable = 0; first_valid = -1;
        prev_stall = 1'b0; prev = '0;
        n_instr = n;
        start   = 1'b1;
        step();
        start   = 1'b0;
        prog_we = 1'b0;
        flags_at_1 = {done, illegal};
        cyc = 1;
        while (busy && cyc < budget) begin
            issue_ready = (mode == 0) ? 1'b1 : rpat[(cyc - 1) % 4];
            cur = {pc, PO, rs, ra, rb, XO, Rc};
            if (issue_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                if (prev_stall && cur !== prev) unstable++;
                if (issue_ready) begin
                    if (hs_cnt < 64) begin
                        hs_fld[hs_cnt] = cur[30:0];
                        hs_pc[hs_cnt]  = pc;
                    end
                    hs_cnt++;
                end else begin
                    stall_cnt++;
                end
            end
            prev_stall = issue_valid && !issue_ready;
            prev = cur;
            step();
            cyc++;
        end
        timed_out = busy;
        end_cyc   = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; n_instr = '0; issue_ready = 1'b0;
        step(); step();
        n_cmp++;
        if ({issue_valid, busy, done, illegal, pc, PO, rs, ra, rb, XO, Rc} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0",
                     {issue_valid, busy, done, illegal, pc, PO, rs, ra, rb, XO, Rc});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        prog_load(6'd0, 32'h7C64_2038);
        run_seq(7'd1, 0, 20);
        n_cmp++;
        if (first_valid !== 3) begin
            n_err++; $display("FAIL single_latency: got %0d required 3", first_valid);
        end
        n_cmp++;
        if (hs_fld[0] !== {6'd31, 5'd3, 5'd4, 5'd4, 9'd28, 1'b0}) begin
            n_err++; $display("FAIL single_fields: got %h required %h", hs_fld[0],
                              {6'd31, 5'd3, 5'd4, 5'd4, 9'd28, 1'b0});
        end
        n_cmp++;
        if ({timed_out, end_cyc, hs_cnt, done, busy, illegal} !== {1'b0, 32'd4, 32'd1, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL single_end: got to=%0b end=%0d hs=%0d done=%0b busy=%0b ill=%0b required 0/4/1/1/0/0",
                              timed_out, end_cyc, hs_cnt, done, busy, illegal);
        end
    endtask

    task automatic test_stall();
        prog_load(6'd0, mkx(5'd5, 5'd6, 5'd7, 9'd266, 1'b1));
        prog_load(6'd1, mkx(5'd1, 5'd2, 5'd3, 9'd316, 1'b0));
        prog_load(6'd2, mkx(5'd31, 5'd0, 5'd17, 9'd444, 1'b1));
        run_seq(7'd3, 1, 60);
        n_cmp++;
        if (hs_cnt !== 3 || stall_cnt !== 3 || end_cyc !== 13 || timed_out) begin
            n_err++; $display("FAIL stall_counts: got hs=%0d stalls=%0d end=%0d to=%0b required 3/3/13/0",
                              hs_cnt, stall_cnt, end_cyc, timed_out);
        end
        n_cmp++;
        if (unstable !== 0) begin
            n_err++; $display("FAIL stall_stable: got %0d changes required 0", unstable);
        end
        n_cmp++;
        if ({hs_pc[0], hs_pc[1], hs_pc[2]} !== {6'd0, 6'd1, 6'd2}) begin
            n_err++; $display("FAIL stall_pc: got %0d %0d %0d required 0 1 2", hs_pc[0], hs_pc[1], hs_pc[2]);
        end
        n_cmp++;
        if (hs_fld[0] !== fx(5'd5, 5'd6, 5'd7, 9'd266, 1'b1) ||
            hs_fld[1] !== fx(5'd1, 5'd2, 5'd3, 9'd316, 1'b0) ||
            hs_fld[2] !== fx(5'd31, 5'd0, 5'd17, 9'd444, 1'b1)) begin
            n_err++; $display("FAIL stall_fields: got %h %h %h", hs_fld[0], hs_fld[1], hs_fld[2]);
        end
        n_cmp++;
        if ({done, illegal, busy} !== 3'b100) begin
            n_err++; $display("FAIL stall_done: got %b required 100", {done, illegal, busy});
        end
    endtask

    task automatic test_illegal();
        prog_load(6'd0, mkx(5'd1, 5'd1, 5'd1, 9'd28, 1'b0));
        prog_load(6'd1, 32'h3860_0001);
        prog_load(6'd2, mkx(5'd2, 5'd2, 5'd2, 9'd40, 1'b0));
        run_seq(7'd3, 0, 40);
        n_cmp++;
        if (hs_cnt !== 1 || valid_cnt !== 1 || hs_pc[0] !== 6'd0 || end_cyc !== 6) begin
            n_err++; $display("FAIL illegal_issue: got hs=%0d valid=%0d pc=%0d end=%0d required 1/1/0/6",
                              hs_cnt, valid_cnt, hs_pc[0], end_cyc);
        end
        n_cmp++;
        if ({done, illegal, busy} !== 3'b110) begin
            n_err++; $display("FAIL illegal_flags: got %b required 110", {done, illegal, busy});
        end
        run_seq(7'd1, 0, 20);
        n_cmp++;
        if (flags_at_1 !== 2'b00 || {done, illegal} !== 2'b10 || hs_cnt !== 1) begin
            n_err++; $display("FAIL illegal_clear: got start=%b end=%b hs=%0d required 00/10/1",
                              flags_at_1, {done, illegal}, hs_cnt);
        end
        prog_load(6'd0, mkx(5'd1, 5'd1, 5'd1, 9'd28, 1'b0) | 32'h0000_0400);
        run_seq(7'd1, 0, 20);
        n_cmp++;
        if ({done, illegal} !== 2'b11 || valid_cnt !== 0) begin
            n_err++; $display("FAIL illegal_bit10: got %b valid=%0d required 11/0", {done, illegal}, valid_cnt);
        end
        prog_load(6'd0, mkx(5'd1, 5'd1, 5'd1, 9'd29, 1'b0));
        run_seq(7'd1, 0, 20);
        n_cmp++;
        if ({done, illegal} !== 2'b11 || valid_cnt !== 0) begin
            n_err++; $display("FAIL illegal_xo: got %b valid=%0d required 11/0", {done, illegal}, valid_cnt);
        end
    endtask

    task automatic test_count_bounds();
        logic [8:0] xo_tab [8];
        int         pc_bad;
        xo_tab = '{9'd28, 9'd60, 9'd124, 9'd316, 9'd444, 9'd476, 9'd266, 9'd40};
        run_seq(7'd0, 0, 20);
        n_cmp++;
        if (end_cyc !== 2 || valid_cnt !== 0 || {done, illegal} !== 2'b10) begin
            n_err++; $display("FAIL zero_count: got end=%0d valid=%0d flags=%b required 2/0/10",
                              end_cyc, valid_cnt, {done, illegal});
        end
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = i[5:0];
            prog_load(a, mkx(a[4:0], ~a[4:0], 5'd9, xo_tab[i % 8], a[0]));
        end
        run_seq(7'd100, 0, 400);
        pc_bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (hs_pc[i] !== i[5:0]) pc_bad++;
        end
        n_cmp++;
        if (hs_cnt !== 64 || timed_out || pc_bad !== 0) begin
            n_err++; $display("FAIL saturate_count: got hs=%0d to=%0b pc_errs=%0d required 64/0/0",
                              hs_cnt, timed_out, pc_bad);
        end
        n_cmp++;
        if (hs_fld[63] !== fx(5'd31, 5'd0, 5'd9, 9'd40, 1'b1) || pc !== 6'd63) begin
            n_err++; $display("FAIL saturate_last: got %h pc=%0d required %h pc=63",
                              hs_fld[63], pc, fx(5'd31, 5'd0, 5'd9, 9'd40, 1'b1));
        end
    endtask

    task automatic test_reset_mid_issue();
        prog_load(6'd0, mkx(5'd7, 5'd8, 5'd9, 9'd476, 1'b1));
        n_instr = 7'd1; issue_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        n_cmp++;
        if (issue_valid !== 1'b1) begin
            n_err++; $display("FAIL midreset_setup: got valid=%b required 1", issue_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({issue_valid, busy, done, illegal, pc, PO, rs, ra, rb, XO, Rc} !== '0) begin
            n_err++; $display("FAIL midreset_async: got %h required 0",
                              {issue_valid, busy, done, illegal, pc, PO, rs, ra, rb, XO, Rc});
        end
        issue_ready = 1'b1;
        step();
        rst_n = 1'b1;
        run_seq(7'd1, 0, 20);
        n_cmp++;
        if (hs_cnt !== 1 || hs_pc[0] !== 6'd0 || first_valid !== 3 ||
            hs_fld[0] !== fx(5'd7, 5'd8, 5'd9, 9'd476, 1'b1)) begin
            n_err++; $display("FAIL midreset_rerun: got hs=%0d pc=%0d first=%0d fld=%h",
                              hs_cnt, hs_pc[0], first_valid, hs_fld[0]);
        end
    endtask

    task automatic test_prog_busy();
        prog_load(6'd0, mkx(5'd10, 5'd11, 5'd12, 9'd124, 1'b0));
        n_instr = 7'd1; issue_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 6'd0; prog_data = mkx(5'd20, 5'd21, 5'd22, 9'd60, 1'b1);
        step(); step(); step();
        prog_we = 1'b0;
        run_seq(7'd1, 0, 20);
        n_cmp++;
        if (hs_cnt !== 1 || hs_fld[0] !== fx(5'd10, 5'd11, 5'd12, 9'd124, 1'b0)) begin
            n_err++; $display("FAIL busy_write: got hs=%0d fld=%h required 1/%h",
                              hs_cnt, hs_fld[0], fx(5'd10, 5'd11, 5'd12, 9'd124, 1'b0));
        end
        prog_we = 1'b1; prog_addr = 6'd0; prog_data = mkx(5'd3, 5'd30, 5'd15, 9'd40, 1'b1);
        run_seq(7'd1, 0, 20);
        n_cmp++;
        if (hs_cnt !== 1 || hs_fld[0] !== fx(5'd3, 5'd30, 5'd15, 9'd40, 1'b1)) begin
            n_err++; $display("FAIL write_with_start: got hs=%0d fld=%h required 1/%h",
                              hs_cnt, hs_fld[0], fx(5'd3, 5'd30, 5'd15, 9'd40, 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_illegal();
        test_count_bounds();
        test_reset_mid_issue();
        test_prog_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
